dm_access_arbiter: RTL and testbench
====================================

// Module: dm_access_arbiter
// PURPOSE
//  Sequences every access to the single-port data memory (DM) and shares it between two requesters:
//  the CPU M-stage data port and an auxiliary word port (debug loader / DMA).
//  Generates byte enables and lane-replicated write data for sb/sh/sw, flags misaligned or out-of-range CPU accesses,
//  and returns raw 32-bit read words; sign/zero extension stays downstream in the load-extend stage.
// PARAMETERS
//  DM_AW     10  DM word-address width (DM = 4*2^DM_AW bytes)
//  WAIT_CYC  1   DM read latency in cycles after the issue edge (min 1)
// PORTS
//  clk        in   1      system clock, rising edge
//  reset_n    in   1      asynchronous, active-low reset
//  cpu_req    in   1      CPU access request; held stable until cpu_ready
//  cpu_we     in   1      1=store, 0=load
//  cpu_size   in   2      00=byte, 01=half, 10=word (11 treated as word)
//  cpu_addr   in   32     byte address
//  cpu_wdata  in   32     store data, right-aligned
//  cpu_ready  out  1      one-cycle completion pulse
//  cpu_rdata  out  32     raw DM word; valid while cpu_ready=1
//  cpu_exc    out  1      with cpu_ready: access misaligned or out of range, DM untouched
//  aux_req    in   1      aux word request; held stable until aux_ready
//  aux_we     in   1      1=write, 0=read
//  aux_addr   in   32     byte address; [1:0] ignored; upper bits truncated to DM_AW
//  aux_wdata  in   32     write word
//  aux_ready  out  1      one-cycle completion pulse
//  aux_rdata  out  32     read word; valid while aux_ready=1
//  dm_en      out  1      DM access strobe
//  dm_we      out  4      DM byte write enables (bit i = byte lane i)
//  dm_addr    out  DM_AW  DM word address
//  dm_wdata   out  32     DM write data
//  dm_rdata   in   32     DM read data, valid WAIT_CYC cycles after issue edge
//  busy       out  1      FSM not in IDLE
// BEHAVIOUR
//  Reset: FSM=IDLE; every output 0; last_grant=AUX, so the CPU wins the first tie.
//  FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//  IDLE: sample requests, latch the winner's fields, and go to ISSUE.
//   - One request active: that requester wins.
//   - Both active: round-robin, i.e. the requester not in last_grant wins; last_grant updates on the grant.
//  CPU error check in IDLE: exc if half with addr[0]!=0, word with addr[1:0]!=0, or addr[31:DM_AW+2]!=0.
//   - exc -> go straight to RESP with cpu_exc=1, no dm_en, rdata=0.
//  ISSUE (1 cycle): dm_en=1, dm_addr=addr[DM_AW+1:2].
//   - Write: dm_we per byte-enable rules below. Read: dm_we=0.
//   - Load wait counter with WAIT_CYC-1.
//  WAIT: decrement the counter. At 0, capture dm_rdata into the rdata register on that edge (reads only), then go to RESP.
//  RESP (1 cycle): ready=1 to the granted requester only; rdata/exc driven from registers. Then IDLE.
//  Latency: request seen in cycle T -> ready in cycle T+2+WAIT_CYC (exc path: T+1).
//   - Back-to-back from one requester: at most one access per 3+WAIT_CYC cycles.
//  Byte enables (CPU):
//   - byte: 4'b0001<<addr[1:0], wdata={4{wdata[7:0]}}
//   - half: 4'b0011<<{addr[1],1'b0}, wdata={2{wdata[15:0]}}
//   - word: 4'b1111, wdata unchanged
//  Aux write: dm_we=4'b1111. dm_we/dm_wdata are 0 outside ISSUE; dm_addr holds its last value.
//  Request dropped mid-access: the latched access still completes and ready still pulses (the protocol forbids dropping).
//  Requests are not sampled in ISSUE/WAIT/RESP; a request raised then waits for the next IDLE.
//  Aux never raises exc; out-of-range aux addresses wrap by truncation.
//  reset_n low in any state: immediate return to IDLE, the pending access is abandoned with no ready pulse.
//   - dm_en/dm_we drop asynchronously.
//  Invariant: cpu_ready and aux_ready are never both 1; dm_en is 1 only in ISSUE.
// TESTING
//  1 CPU sw addr 0x10, data 0xA5A5_1234, WAIT_CYC=1
//     -> ISSUE cycle shows dm_addr=4, dm_we=1111; cpu_ready at T+3.
//     -> A following lw 0x10 returns cpu_rdata=0xA5A5_1234.
//  2 CPU sb addr 0x13, wdata 0x0000_00EE
//     -> dm_we=1000, dm_wdata=0xEEEE_EEEE.
//     -> A later lw 0x10 reads 0xEEA5_1234 (from scenario 1 contents).
//  3 CPU lh addr 0x11 -> cpu_ready+cpu_exc at T+1, dm_en never asserted.
//     CPU lw addr 0x0000_1000 with DM_AW=10 -> exc.
//  4 cpu_req and aux_req both high for 4 accesses, starting from reset -> grant order CPU, AUX, CPU, AUX.
//     -> Never two ready pulses in the same cycle.
//  5 Aux sw addr 0x23 -> dm_addr=8, dm_we=1111, no exc.
//     Rerun with WAIT_CYC=3 -> ready at T+5 and rdata captured correctly.
//  6 reset_n asserted during WAIT -> busy=0, all outputs 0 immediately, no ready pulse.
//     A new CPU request after release completes normally.

Source files
------------

// File: rtl/dm_access_arbiter_if.sv
// dm_access_arbiter_if
//   Bundles every handshake and memory-side signal of dm_access_arbiter.
//   The arbiter connects through the slave modport. The requesters and the
//   data memory (or a bench standing in for them) connect through master.
//
//   CPU data port : cpu_req/cpu_we/cpu_size/cpu_addr/cpu_wdata in,
//                   cpu_ready/cpu_rdata/cpu_exc out
//   Aux word port : aux_req/aux_we/aux_addr/aux_wdata in,
//                   aux_ready/aux_rdata out
//   DM port       : dm_en/dm_we/dm_addr/dm_wdata out, dm_rdata in
//   Status        : busy out
interface dm_access_arbiter_if #(
    parameter int DM_AW = 10
);
    logic             cpu_req;
    logic             cpu_we;
    logic [1:0]       cpu_size;
    logic [31:0]      cpu_addr;
    logic [31:0]      cpu_wdata;
    logic             cpu_ready;
    logic [31:0]      cpu_rdata;
    logic             cpu_exc;

    logic             aux_req;
    logic             aux_we;
    logic [31:0]      aux_addr;
    logic [31:0]      aux_wdata;
    logic             aux_ready;
    logic [31:0]      aux_rdata;

    logic             dm_en;
    logic [3:0]       dm_we;
    logic [DM_AW-1:0] dm_addr;
    logic [31:0]      dm_wdata;
    logic [31:0]      dm_rdata;

    logic             busy;

    modport slave (
        input  cpu_req, cpu_we, cpu_size, cpu_addr, cpu_wdata,
        output cpu_ready, cpu_rdata, cpu_exc,
        input  aux_req, aux_we, aux_addr, aux_wdata,
        output aux_ready, aux_rdata,
        output dm_en, dm_we, dm_addr, dm_wdata,
        input  dm_rdata,
        output busy
    );

    modport master (
        output cpu_req, cpu_we, cpu_size, cpu_addr, cpu_wdata,
        input  cpu_ready, cpu_rdata, cpu_exc,
        output aux_req, aux_we, aux_addr, aux_wdata,
        input  aux_ready, aux_rdata,
        input  dm_en, dm_we, dm_addr, dm_wdata,
        output dm_rdata,
        input  busy
    );
endinterface

// File: rtl/dm_access_arbiter.sv
// dm_access_arbiter
//   Sequences all accesses to the single-port data memory and shares it
//   between the CPU M-stage data port and an auxiliary word port.
//   CPU stores get byte enables and lane-replicated write data for sb/sh/sw.
//   Misaligned or out-of-range CPU accesses complete with cpu_exc and never
//   touch the memory. Reads return the raw 32-bit word; sign and zero
//   extension happen downstream.
//
//   Parameters
//     DM_AW     DM word-address width (DM holds 4*2^DM_AW bytes)
//     WAIT_CYC  DM read latency in cycles after the issue edge (>= 1)
//
//   Ports
//     clk      system clock, rising edge
//     reset_n  asynchronous active-low reset
//     bus      dm_access_arbiter_if.slave: CPU port, aux port, DM port, busy
//
//   Access flow: IDLE -> ISSUE -> WAIT (WAIT_CYC cycles) -> RESP -> IDLE.
//   A faulting CPU access goes IDLE -> RESP directly.
module dm_access_arbiter #(
    parameter int DM_AW    = 10,
    parameter int WAIT_CYC = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    dm_access_arbiter_if.slave  bus
);

    localparam int CNT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic             r_last_aux;   // 1: aux held the last grant
    logic             r_gnt_cpu;
    logic             r_we;
    logic             r_exc;
    logic [3:0]       r_be;
    logic [31:0]      r_wdata;
    logic [31:0]      r_rdata;
    logic [DM_AW-1:0] r_dm_addr;
    logic [CNT_W-1:0] r_cnt;

    logic             w_cpu_win;
    logic             w_aux_win;
    logic             w_cpu_fault;
    logic             w_unused;

    function automatic logic [3:0] cpu_byte_en(input logic [1:0] size,
                                               input logic [1:0] a);
        case (size)
            2'b00:   return 4'b0001 << a;
            2'b01:   return 4'b0011 << {a[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] cpu_lanes(input logic [1:0]  size,
                                              input logic [31:0] d);
        case (size)
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic cpu_fault(input logic [1:0]  size,
                                       input logic [31:0] a);
        logic misaligned;
        logic out_of_range;
        misaligned   = ((size == 2'b01) && a[0]) ||
                       (size[1] && (a[1:0] != 2'b00));
        out_of_range = ((a >> (DM_AW + 2)) != 32'd0);
        return misaligned || out_of_range;
    endfunction

    // Round-robin tie break: with both requesting, the side that did not
    // hold the last grant wins. r_last_aux resets to 1 so the CPU wins first.
    assign w_cpu_win   = bus.cpu_req && (!bus.aux_req || r_last_aux);
    assign w_aux_win   = bus.aux_req && !w_cpu_win;
    assign w_cpu_fault = cpu_fault(bus.cpu_size, bus.cpu_addr);

    // Aux byte offset and the bits above the DM range are deliberately dropped.
    assign w_unused = ^{bus.aux_addr[31:DM_AW+2], bus.aux_addr[1:0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        bus.dm_en     = 1'b0;
        bus.dm_we     = 4'b0000;
        bus.dm_wdata  = 32'd0;
        bus.dm_addr   = r_dm_addr;
        bus.cpu_ready = 1'b0;
        bus.cpu_rdata = 32'd0;
        bus.cpu_exc   = 1'b0;
        bus.aux_ready = 1'b0;
        bus.aux_rdata = 32'd0;
        bus.busy      = (r_state != S_IDLE);

        case (r_state)
            S_IDLE: begin
                if (w_cpu_win) begin
                    w_state_nxt = w_cpu_fault ? S_RESP : S_ISSUE;
                end else if (w_aux_win) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                bus.dm_en   = 1'b1;
                if (r_we) begin
                    bus.dm_we    = r_be;
                    bus.dm_wdata = r_wdata;
                end
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (r_gnt_cpu) begin
                    bus.cpu_ready = 1'b1;
                    bus.cpu_rdata = r_rdata;
                    bus.cpu_exc   = r_exc;
                end else begin
                    bus.aux_ready = 1'b1;
                    bus.aux_rdata = r_rdata;
                end
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_aux <= 1'b1;
            r_gnt_cpu  <= 1'b0;
            r_we       <= 1'b0;
            r_exc      <= 1'b0;
            r_be       <= 4'b0000;
            r_wdata    <= 32'd0;
            r_rdata    <= 32'd0;
            r_dm_addr  <= '0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_cpu_win) begin
                        r_last_aux <= 1'b0;
                        r_gnt_cpu  <= 1'b1;
                        r_we       <= bus.cpu_we;
                        r_exc      <= w_cpu_fault;
                        r_be       <= cpu_byte_en(bus.cpu_size, bus.cpu_addr[1:0]);
                        r_wdata    <= cpu_lanes(bus.cpu_size, bus.cpu_wdata);
                        r_rdata    <= 32'd0;
                        // A faulting access never reaches the DM, so the
                        // visible address keeps the last real access.
                        if (!w_cpu_fault) begin
                            r_dm_addr <= bus.cpu_addr[DM_AW+1:2];
                        end
                    end else if (w_aux_win) begin
                        r_last_aux <= 1'b1;
                        r_gnt_cpu  <= 1'b0;
                        r_we       <= bus.aux_we;
                        r_exc      <= 1'b0;
                        r_be       <= 4'b1111;
                        r_wdata    <= bus.aux_wdata;
                        r_rdata    <= 32'd0;
                        r_dm_addr  <= bus.aux_addr[DM_AW+1:2];
                    end
                end
                S_ISSUE: begin
                    r_cnt <= CNT_LOAD;
                end
                S_WAIT: begin
                    if (r_cnt == '0) begin
                        if (!r_we) begin
                            r_rdata <= bus.dm_rdata;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_access_arbiter.sv
module tb_dm_access_arbiter;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int sel      = 0;   // 0: WAIT_CYC=1 instance, 1: WAIT_CYC=3 instance
    int en_cnt   = 0;

    // Requester drive (routed to the selected instance only)
    logic        t_cpu_req, t_cpu_we, t_aux_req, t_aux_we;
    logic [1:0]  t_cpu_size;
    logic [31:0] t_cpu_addr, t_cpu_wdata, t_aux_addr, t_aux_wdata;

    // Observed outputs of the selected instance
    logic        o_cpu_ready, o_cpu_exc, o_aux_ready, o_dm_en, o_busy;
    logic [31:0] o_cpu_rdata, o_aux_rdata, o_dm_wdata;
    logic [3:0]  o_dm_we;
    logic [9:0]  o_dm_addr;
    logic [31:0] m_rdata;

    dm_access_arbiter_if #(.DM_AW(10)) bus0 ();
    dm_access_arbiter_if #(.DM_AW(10)) bus1 ();

    dm_access_arbiter #(.DM_AW(10), .WAIT_CYC(1)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .bus(bus0.slave));
    dm_access_arbiter #(.DM_AW(10), .WAIT_CYC(3)) u_dut3 (
        .clk(clk), .reset_n(reset_n), .bus(bus1.slave));

    assign bus0.cpu_req   = t_cpu_req && (sel == 0);
    assign bus0.aux_req   = t_aux_req && (sel == 0);
    assign bus1.cpu_req   = t_cpu_req && (sel == 1);
    assign bus1.aux_req   = t_aux_req && (sel == 1);
    assign bus0.cpu_we    = t_cpu_we;    assign bus1.cpu_we    = t_cpu_we;
    assign bus0.cpu_size  = t_cpu_size;  assign bus1.cpu_size  = t_cpu_size;
    assign bus0.cpu_addr  = t_cpu_addr;  assign bus1.cpu_addr  = t_cpu_addr;
    assign bus0.cpu_wdata = t_cpu_wdata; assign bus1.cpu_wdata = t_cpu_wdata;
    assign bus0.aux_we    = t_aux_we;    assign bus1.aux_we    = t_aux_we;
    assign bus0.aux_addr  = t_aux_addr;  assign bus1.aux_addr  = t_aux_addr;
    assign bus0.aux_wdata = t_aux_wdata; assign bus1.aux_wdata = t_aux_wdata;
    assign bus0.dm_rdata  = m_rdata;     assign bus1.dm_rdata  = m_rdata;

    assign o_cpu_ready = (sel == 1) ? bus1.cpu_ready : bus0.cpu_ready;
    assign o_cpu_rdata = (sel == 1) ? bus1.cpu_rdata : bus0.cpu_rdata;
    assign o_cpu_exc   = (sel == 1) ? bus1.cpu_exc   : bus0.cpu_exc;
    assign o_aux_ready = (sel == 1) ? bus1.aux_ready : bus0.aux_ready;
    assign o_aux_rdata = (sel == 1) ? bus1.aux_rdata : bus0.aux_rdata;
    assign o_dm_en     = (sel == 1) ? bus1.dm_en     : bus0.dm_en;
    assign o_dm_we     = (sel == 1) ? bus1.dm_we     : bus0.dm_we;
    assign o_dm_addr   = (sel == 1) ? bus1.dm_addr   : bus0.dm_addr;
    assign o_dm_wdata  = (sel == 1) ? bus1.dm_wdata  : bus0.dm_wdata;
    assign o_busy      = (sel == 1) ? bus1.busy      : bus0.busy;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int cur_wc();
        return (sel == 1) ? 3 : 1;
    endfunction

    // Shared data memory: read data is valid exactly cur_wc() edges after
    // the issue edge and shows a junk pattern otherwise.
    logic [31:0] mem [0:1023];
    logic [31:0] rd_pipe [0:2];
    logic [2:0]  rd_vld = 3'b000;
    initial for (int i = 0; i < 1024; i++) mem[i] = 32'd0;

    always @(posedge clk) begin
        if (o_dm_en) begin
            for (int b = 0; b < 4; b++)
                if (o_dm_we[b]) mem[o_dm_addr][b*8 +: 8] <= o_dm_wdata[b*8 +: 8];
        end
        rd_pipe[0] <= mem[o_dm_addr];
        rd_pipe[1] <= rd_pipe[0];
        rd_pipe[2] <= rd_pipe[1];
        rd_vld     <= {rd_vld[1:0], o_dm_en && (o_dm_we == 4'b0000)};
    end
    assign m_rdata = rd_vld[cur_wc()-1] ? rd_pipe[cur_wc()-1] : 32'hDEAD_BEEF;

    // Last DM issue as seen on the bus
    logic [9:0]  l_addr;
    logic [3:0]  l_we;
    logic [31:0] l_wdata;
    always @(negedge clk) begin
        if (o_dm_en) begin
            en_cnt  = en_cnt + 1;
            l_addr  = o_dm_addr;
            l_we    = o_dm_we;
            l_wdata = o_dm_wdata;
        end
    end

    // Scoreboard of expected responses, in grant order
    typedef struct {
        bit          is_cpu;
        logic [31:0] rdata;
        bit          exc;
        int          cyc;
        string       tag;
    } exp_t;
    exp_t exp_q[$];

    logic [31:0] mon_rd;
    exp_t        mon_e;
    always @(negedge clk) begin
        if (o_cpu_ready || o_aux_ready) begin
            checks++;
            assert (!(o_cpu_ready && o_aux_ready)) else begin
                failures++;
                $error("FAIL dual_ready cpu_ready=%0b aux_ready=%0b required one", o_cpu_ready, o_aux_ready);
            end
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_ready cycle=%0d cpu=%0b aux=%0b required none", cyc, o_cpu_ready, o_aux_ready);
            end
            if (exp_q.size() != 0) begin
                mon_e  = exp_q.pop_front();
                mon_rd = o_cpu_ready ? o_cpu_rdata : o_aux_rdata;
                checks++;
                assert (o_cpu_ready === mon_e.is_cpu) else begin
                    failures++;
                    $error("FAIL %s_who cpu_ready=%0b required %0b", mon_e.tag, o_cpu_ready, mon_e.is_cpu);
                end
                checks++;
                assert (mon_rd === mon_e.rdata) else begin
                    failures++;
                    $error("FAIL %s_rdata got=%h required %h", mon_e.tag, mon_rd, mon_e.rdata);
                end
                checks++;
                assert (o_cpu_exc === mon_e.exc) else begin
                    failures++;
                    $error("FAIL %s_exc got=%0b required %0b", mon_e.tag, o_cpu_exc, mon_e.exc);
                end
                checks++;
                assert (cyc === mon_e.cyc) else begin
                    failures++;
                    $error("FAIL %s_latency ready_cycle=%0d required %0d", mon_e.tag, cyc, mon_e.cyc);
                end
            end
        end
    end

    task automatic chk(input logic [31:0] got, input logic [31:0] expv, input string tag);
        checks++;
        assert (got === expv) else begin
            failures++;
            $error("FAIL %s got=%h required %h", tag, got, expv);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input bit is_cpu, input logic [31:0] rd, input bit exc,
                            input int lat, input string tag);
        exp_t e;
        e.is_cpu = is_cpu; e.rdata = rd; e.exc = exc; e.cyc = cyc + lat; e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic wait_ready(input bit is_cpu, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            seen = is_cpu ? o_cpu_ready : o_aux_ready;
        end
        checks++;
        assert (seen) else begin
            failures++;
            $error("FAIL %s_timeout ready=0 required 1 within 30 cycles", tag);
        end
        step(1);
    endtask

    task automatic cpu_go(input bit we, input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rd,
                          input bit exc, input string tag);
        t_cpu_we = we; t_cpu_size = size; t_cpu_addr = addr; t_cpu_wdata = wdata;
        t_cpu_req = 1'b1;
        push_exp(1'b1, exp_rd, exc, exc ? 1 : 2 + cur_wc(), tag);
        wait_ready(1'b1, tag);
        t_cpu_req = 1'b0;
    endtask

    task automatic aux_go(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rd, input string tag);
        t_aux_we = we; t_aux_addr = addr; t_aux_wdata = wdata;
        t_aux_req = 1'b1;
        push_exp(1'b0, exp_rd, 1'b0, 2 + cur_wc(), tag);
        wait_ready(1'b0, tag);
        t_aux_req = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({27'd0, o_busy, o_cpu_ready, o_aux_ready, o_dm_en, o_cpu_exc}, 32'd0, {tag, "_ctrl"});
        chk({28'd0, o_dm_we}, 32'd0, {tag, "_dm_we"});
        chk({22'd0, o_dm_addr}, 32'd0, {tag, "_dm_addr"});
        chk(o_dm_wdata, 32'd0, {tag, "_dm_wdata"});
        chk(o_cpu_rdata, 32'd0, {tag, "_cpu_rdata"});
        chk(o_aux_rdata, 32'd0, {tag, "_aux_rdata"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int seen;
        t_cpu_req = 0; t_cpu_we = 0; t_cpu_size = 0; t_cpu_addr = 0; t_cpu_wdata = 0;
        t_aux_req = 0; t_aux_we = 0; t_aux_addr = 0; t_aux_wdata = 0;

        // Reset state
        step(3);
        chk_all_zero("reset");
        reset_n = 1'b1;
        step(1);

        // Word store then load back
        cpu_go(1, 2'b10, 32'h10, 32'hA5A5_1234, 32'd0, 0, "sw10");
        chk({22'd0, l_addr}, 32'd4, "sw10_dm_addr");
        chk({28'd0, l_we}, 32'hF, "sw10_dm_we");
        chk(l_wdata, 32'hA5A5_1234, "sw10_dm_wdata");
        cpu_go(0, 2'b10, 32'h10, 32'd0, 32'hA5A5_1234, 0, "lw10");
        chk({28'd0, l_we}, 32'd0, "lw10_dm_we");

        // Byte and half stores with lane replication
        cpu_go(1, 2'b00, 32'h13, 32'h0000_00EE, 32'd0, 0, "sb13");
        chk({28'd0, l_we}, 32'h8, "sb13_dm_we");
        chk(l_wdata, 32'hEEEE_EEEE, "sb13_dm_wdata");
        cpu_go(0, 2'b10, 32'h10, 32'd0, 32'hEEA5_1234, 0, "lw10_after_sb");
        cpu_go(1, 2'b01, 32'h16, 32'h0000_BEEF, 32'd0, 0, "sh16");
        chk({28'd0, l_we}, 32'hC, "sh16_dm_we");
        chk(l_wdata, 32'hBEEF_BEEF, "sh16_dm_wdata");
        cpu_go(0, 2'b01, 32'h16, 32'd0, 32'hBEEF_0000, 0, "lh16_raw");

        // Faulting CPU accesses never reach the DM
        n = en_cnt;
        cpu_go(0, 2'b01, 32'h11, 32'd0, 32'd0, 1, "lh11_exc");
        cpu_go(0, 2'b10, 32'h0000_1000, 32'd0, 32'd0, 1, "lw1000_exc");
        cpu_go(1, 2'b10, 32'h12, 32'hFFFF_FFFF, 32'd0, 1, "sw12_exc");
        chk(en_cnt, n, "exc_no_dm_en");
        chk({22'd0, o_dm_addr}, 32'd5, "dm_addr_hold");
        cpu_go(0, 2'b10, 32'h10, 32'd0, 32'hEEA5_1234, 0, "lw10_after_exc");
        cpu_go(0, 2'b10, 32'h0000_0FFC, 32'd0, 32'd0, 0, "lw_top_word");

        // Aux word port, including address truncation
        aux_go(1, 32'h23, 32'hCAFE_F00D, 32'd0, "aux_sw23");
        chk({22'd0, l_addr}, 32'd8, "aux_sw23_dm_addr");
        chk({28'd0, l_we}, 32'hF, "aux_sw23_dm_we");
        chk(l_wdata, 32'hCAFE_F00D, "aux_sw23_dm_wdata");
        aux_go(0, 32'h0000_1020, 32'd0, 32'hCAFE_F00D, "aux_rd_wrap");
        chk({22'd0, l_addr}, 32'd8, "aux_wrap_dm_addr");

        // Both requesters continuously active from reset: CPU, AUX, CPU, AUX
        reset_n = 1'b0;
        step(2);
        reset_n = 1'b1;
        step(1);
        t_cpu_we = 0; t_cpu_size = 2'b10; t_cpu_addr = 32'h10;
        t_aux_we = 0; t_aux_addr = 32'h20;
        t_cpu_req = 1; t_aux_req = 1;
        push_exp(1'b1, 32'hEEA5_1234, 1'b0, 3,  "rr0_cpu");
        push_exp(1'b0, 32'hCAFE_F00D, 1'b0, 7,  "rr1_aux");
        push_exp(1'b1, 32'hEEA5_1234, 1'b0, 11, "rr2_cpu");
        push_exp(1'b0, 32'hCAFE_F00D, 1'b0, 15, "rr3_aux");
        seen = 0;
        for (int i = 0; i < 40 && seen < 4; i++) begin
            @(negedge clk);
            if (o_cpu_ready || o_aux_ready) seen++;
        end
        chk(seen, 4, "rr_pulse_count");
        step(1);
        t_cpu_req = 0; t_aux_req = 0;
        chk(exp_q.size(), 0, "rr_queue_drained");

        // Reset during ISSUE drops the strobe at once and cancels the store
        t_cpu_we = 1; t_cpu_size = 2'b10; t_cpu_addr = 32'h30; t_cpu_wdata = 32'h1111_1111;
        t_cpu_req = 1;
        step(1);
        chk({31'd0, o_dm_en}, 32'd1, "issue_dm_en");
        chk({28'd0, o_dm_we}, 32'hF, "issue_dm_we");
        #2 reset_n = 1'b0;
        #1 chk_all_zero("rst_issue");
        t_cpu_req = 0;
        step(2);
        reset_n = 1'b1;
        step(1);
        cpu_go(0, 2'b10, 32'h30, 32'd0, 32'd0, 0, "lw30_untouched");

        // Longer DM latency
        sel = 1;
        step(1);
        aux_go(1, 32'h40, 32'h1234_5678, 32'd0, "w3_aux_wr");
        aux_go(0, 32'h40, 32'd0, 32'h1234_5678, "w3_aux_rd");
        cpu_go(0, 2'b10, 32'h10, 32'd0, 32'hEEA5_1234, 0, "w3_cpu_lw");

        // Reset during WAIT abandons the access with no ready pulse
        t_cpu_we = 0; t_cpu_size = 2'b10; t_cpu_addr = 32'h10;
        t_cpu_req = 1;
        step(3);
        chk({31'd0, o_busy}, 32'd1, "wait_busy");
        #2 reset_n = 1'b0;
        #1 chk_all_zero("rst_wait");
        t_cpu_req = 0;
        step(2);
        reset_n = 1'b1;
        step(6);
        chk({31'd0, o_busy}, 32'd0, "post_reset_idle");
        chk(exp_q.size(), 0, "post_reset_no_pending");
        cpu_go(0, 2'b10, 32'h40, 32'd0, 32'h1234_5678, 0, "post_reset_lw");

        step(2);
        chk(exp_q.size(), 0, "final_queue_empty");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
